irq_controller: RTL and testbench

//  Trap arbiter directly upstream of the CSR controller. It collects a synchronous

---
 rtl/irq_controller.sv | 128 ++++++++++++
 tb/tb_irq_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Trap arbiter in front of the CSR controller: merges the exception flag with
// mie-gated, fixed-priority external interrupts and tracks handler service until mret.
module irq_controller #(
  parameter int IRQ_NUM    = 16,
  parameter int CAUSE_BASE = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               exception_i,
  input  logic               mret_i,
  input  logic [31:0]        mie_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  output logic               trap_o,
  output logic [31:0]        mcause_o,
  output logic               irq_o,
  output logic [IRQ_NUM-1:0] irq_ret_o,
  output logic               busy_o
);

  localparam int ID_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
  localparam logic [31:0] EXC_CAUSE = 32'h0000_0002;
  localparam logic [31:0] IRQ_FLAG  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXC     = 2'd1,
    IRQ     = 2'd2,
    IRQ_EXC = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IRQ_NUM-1:0] pend_q;
  logic [ID_W-1:0]    cur_id_q;
  logic [IRQ_NUM-1:0] eligible;
  logic [IRQ_NUM-1:0] take_mask;
  logic [ID_W-1:0]    sel_id;
  logic               any_elig;
  logic               take;

  // Only the mie bits belonging to our lines matter; fold the rest away.
  logic unused_mie;
  assign unused_mie = ^mie_i;

  // Descending scan so the lowest eligible line is the one left selected.
  always_comb begin
    eligible = '0;
    any_elig = 1'b0;
    sel_id   = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      eligible[k] = (pend_q[k] | irq_req_i[k]) & mie_i[CAUSE_BASE + k];
      if (eligible[k]) begin
        any_elig = 1'b1;
        sel_id   = ID_W'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    trap_o    = 1'b0;
    irq_o     = 1'b0;
    mcause_o  = '0;
    irq_ret_o = '0;
    take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exception_i) begin
          trap_o   = 1'b1;
          mcause_o = EXC_CAUSE;
          state_d  = EXC;
        end else if (any_elig) begin
          trap_o   = 1'b1;
          irq_o    = 1'b1;
          mcause_o = IRQ_FLAG | (32'(CAUSE_BASE) + {{(32-ID_W){1'b0}}, sel_id});
          take     = 1'b1;
          state_d  = IRQ;
        end
      end
      EXC: begin
        if (exception_i) begin
          trap_o   = 1'b1;
          mcause_o = EXC_CAUSE;
        end else if (mret_i) begin
          state_d = IDLE;
        end
      end
      IRQ: begin
        if (exception_i) begin
          trap_o   = 1'b1;
          mcause_o = EXC_CAUSE;
          state_d  = IRQ_EXC;
        end else if (mret_i) begin
          irq_ret_o = IRQ_NUM'(1) << cur_id_q;
          state_d   = IDLE;
        end
      end
      IRQ_EXC: begin
        if (exception_i) begin
          trap_o   = 1'b1;
          mcause_o = EXC_CAUSE;
        end else if (mret_i) begin
          state_d = IRQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign take_mask = take ? (IRQ_NUM'(1) << sel_id) : '0;

  // Requests are sticky; the clear for the line being taken overrides a same-cycle set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      cur_id_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= (pend_q | irq_req_i) & ~take_mask;
      if (take) begin
        cur_id_q <= sel_id;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a table of per-cycle vectors with
// hand-computed expectations plus a hand-written mie-gating sequence.
module tb_irq_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        exception_i;
  logic        mret_i;
  logic [31:0] mie_i;
  logic [15:0] irq_req_i;
  logic        trap_o;
  logic [31:0] mcause_o;
  logic        irq_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        exc;
    logic        mret;
    logic [31:0] mie;
    logic [15:0] req;
    logic        trap;
    logic        irq;
    logic [31:0] cause;
    logic [15:0] ret;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  irq_controller #(.IRQ_NUM(16), .CAUSE_BASE(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .exception_i (exception_i),
    .mret_i      (mret_i),
    .mie_i       (mie_i),
    .irq_req_i   (irq_req_i),
    .trap_o      (trap_o),
    .mcause_o    (mcause_o),
    .irq_o       (irq_o),
    .irq_ret_o   (irq_ret_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic rst, logic exc, logic mret, logic [31:0] mie,
                              logic [15:0] req, logic trap, logic irq,
                              logic [31:0] cause, logic [15:0] ret, logic busy);
    vec_t v;
    v.rst = rst; v.exc = exc; v.mret = mret; v.mie = mie; v.req = req;
    v.trap = trap; v.irq = irq; v.cause = cause; v.ret = ret; v.busy = busy;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk_i);
    rst_i       = v.rst;
    exception_i = v.exc;
    mret_i      = v.mret;
    mie_i       = v.mie;
    irq_req_i   = v.req;
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    cmp({tag, " trap"},   32'(trap_o),    32'(v.trap));
    cmp({tag, " irq"},    32'(irq_o),     32'(v.irq));
    cmp({tag, " mcause"}, mcause_o,       v.cause);
    cmp({tag, " ret"},    32'(irq_ret_o), 32'(v.ret));
    cmp({tag, " busy"},   32'(busy_o),    32'(v.busy));
  endtask

  initial begin
    vec_t v;

    // Reset state, then single pulse on line 0 taken combinationally.
    vecs.push_back(mk(1, 0, 0, 32'h0000_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0001_0000, 16'h0001, 1, 1, 32'h8000_0010, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0001_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0001_0000, 16'h0000, 0, 0, 32'h0, 16'h0001, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0001_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));
    // Priority between lines 1 and 2, back-to-back service after mret.
    vecs.push_back(mk(0, 0, 0, 32'h0006_0000, 16'h0006, 1, 1, 32'h8000_0011, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0006_0000, 16'h0000, 0, 0, 32'h0, 16'h0002, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0006_0000, 16'h0000, 1, 1, 32'h8000_0012, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0006_0000, 16'h0000, 0, 0, 32'h0, 16'h0004, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0006_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));
    // Exception beats an eligible interrupt; the interrupt waits in pend.
    vecs.push_back(mk(0, 1, 0, 32'h0008_0000, 16'h0008, 1, 0, 32'h2, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0008_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0008_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0008_0000, 16'h0000, 1, 1, 32'h8000_0013, 16'h0000, 0));
    // Exception inside IRQ handler, nested return then ack of line 3.
    vecs.push_back(mk(0, 1, 0, 32'h0008_0000, 16'h0000, 1, 0, 32'h2, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0008_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0008_0000, 16'h0000, 0, 0, 32'h0, 16'h0008, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0008_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));
    // Exception and mret together in EXC: exception wins, state stays EXC.
    vecs.push_back(mk(0, 1, 0, 32'h0000_0000, 16'h0000, 1, 0, 32'h2, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_0000, 16'h0000, 1, 0, 32'h2, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0000_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0000_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));
    // mret in IDLE is ignored.
    vecs.push_back(mk(0, 0, 1, 32'h0000_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0000_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));
    // Reset mid-handler drops state, cur_id and a pending line 6.
    vecs.push_back(mk(0, 0, 0, 32'h0050_0000, 16'h0010, 1, 1, 32'h8000_0014, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0050_0000, 16'h0040, 0, 0, 32'h0, 16'h0000, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0050_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0050_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0050_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0));

    rst_i = 1'b1; exception_i = 1'b0; mret_i = 1'b0; mie_i = '0; irq_req_i = '0;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Pulse on line 5 with its mie bit clear: held pending for 10 cycles, then taken.
    v = mk(0, 0, 0, 32'h0000_0000, 16'h0020, 0, 0, 32'h0, 16'h0000, 0);
    applyStimulus(v);
    checkOutput("gate pulse", v);
    v.req = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(v);
      checkOutput($sformatf("gate wait%0d", c), v);
    end
    v = mk(0, 0, 0, 32'h0020_0000, 16'h0000, 1, 1, 32'h8000_0015, 16'h0000, 0);
    applyStimulus(v);
    checkOutput("gate take", v);
    v = mk(0, 0, 1, 32'h0020_0000, 16'h0000, 0, 0, 32'h0, 16'h0020, 1);
    applyStimulus(v);
    checkOutput("gate ret", v);
    v = mk(0, 0, 0, 32'h0020_0000, 16'h0000, 0, 0, 32'h0, 16'h0000, 0);
    applyStimulus(v);
    checkOutput("gate idle", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
